// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between NUM_REQ producers and the register-bank write arbiter,
// including the bank-side write port and the forwarding lookup.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [2:0]                grant_id;
  logic                      busy;
  logic [ADDR_W-1:0]         byp_addr;
  logic                      byp_hit;
  logic [DATA_W-1:0]         byp_data;

  modport slave (
    input  req_valid, req_addr, req_data, byp_addr,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, busy, byp_hit, byp_data
  );

  modport master (
    output req_valid, req_addr, req_data, byp_addr,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, busy, byp_hit, byp_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between NUM_REQ sources.
// Define WB_ARB_BYPASS_EN to forward the staged write through byp_hit/byp_data.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input logic                clk,
  input logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] buf_vld_p0;
  logic [ADDR_W-1:0]  buf_addr_p0 [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_p0 [NUM_REQ];
  logic [2:0]         ptr;

  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [2:0]         gid_p1;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] load;
  logic               any_lo, any_hi, gany;
  logic [2:0]         idx_lo, idx_hi, sel;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Round robin as two priority scans: lowest valid at/after ptr, else lowest overall.
  always_comb begin
    any_lo = 1'b0;
    any_hi = 1'b0;
    idx_lo = 3'd0;
    idx_hi = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (buf_vld_p0[i]) begin
        any_lo = 1'b1;
        idx_lo = 3'(i);
      end
      if (buf_vld_p0[i] && (3'(i) >= ptr)) begin
        any_hi = 1'b1;
        idx_hi = 3'(i);
      end
    end
    gany = any_lo;
    sel  = any_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    grant    = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = gany && (sel == 3'(i));
      if (grant[i]) begin
        sel_addr = buf_addr_p0[i];
        sel_data = buf_data_p0[i];
      end
    end
  end

  assign bus.req_ready = ~buf_vld_p0 | grant;

  // Register-0 writes complete the handshake but never occupy a buffer.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_REQ; i++)
      load[i] = bus.req_valid[i] && bus.req_ready[i] &&
                (bus.req_addr[i*ADDR_W +: ADDR_W] != '0);
  end

  // Stage p0: per-requester holding buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i])       buf_vld_p0[i] <= 1'b1;
        else if (grant[i]) buf_vld_p0[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        buf_addr_p0[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
        buf_data_p0[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: registered bank write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      gid_p1  <= 3'd0;
      ptr     <= 3'd0;
    end else begin
      vld_p1 <= gany;
      if (gany) begin
        addr_p1 <= sel_addr;
        data_p1 <= sel_data;
        gid_p1  <= sel;
        ptr     <= (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
      end
    end
  end

  assign bus.wr_en    = vld_p1;
  assign bus.wr_addr  = addr_p1;
  assign bus.wr_data  = data_p1;
  assign bus.grant_id = gid_p1;
  assign bus.busy     = (|buf_vld_p0) | vld_p1;

`ifdef WB_ARB_BYPASS_EN
  always_comb begin
    bus.byp_hit  = vld_p1 && (addr_p1 == bus.byp_addr) && (bus.byp_addr != '0);
    bus.byp_data = bus.byp_hit ? data_p1 : '0;
  end
`else
  logic unused_byp;
  assign unused_byp   = ^bus.byp_addr;
  assign bus.byp_hit  = 1'b0;
  assign bus.byp_data = '0;
`endif

endmodule
